// File: rtl/evm_result_tally_if.sv
// rtl/evm_result_tally_if.sv - control, count and result signals of the EVM result tally
interface evm_result_tally_if #(
  parameter int CNT_W = 4
);
  logic             close_poll;
  logic             clear;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic [CNT_W-1:0] count_c;
  logic [CNT_W-1:0] count_d;
  logic             busy;
  logic             done;
  logic [3:0]       winner;
  logic [CNT_W-1:0] winner_count;
  logic             tie;
  logic             no_votes;
  logic [CNT_W+1:0] total_votes;

  // Voting side: requests a tally and reads the published result
  modport master (
    output close_poll, clear, count_a, count_b, count_c, count_d,
    input  busy, done, winner, winner_count, tie, no_votes, total_votes
  );

  // Tally side
  modport slave (
    input  close_poll, clear, count_a, count_b, count_c, count_d,
    output busy, done, winner, winner_count, tie, no_votes, total_votes
  );
endinterface

// File: rtl/evm_result_tally.sv
// rtl/evm_result_tally.sv - snapshots four vote counters, scans them and publishes the winner
module evm_result_tally #(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  evm_result_tally_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] snap_q [4];

  // Working registers: never visible on the outputs until the publish edge
  logic [CNT_W-1:0] best_q, best_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W+1:0] sum_q, sum_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] v;

  // Published result registers
  logic             busy_q;
  logic             done_q;
  logic [3:0]       winner_q;
  logic [CNT_W-1:0] winner_count_q;
  logic             tie_out_q;
  logic             no_votes_q;
  logic [CNT_W+1:0] total_q;

  // One scan step: fold the candidate at idx into the running max/mask/sum
  always_comb begin
    v      = snap_q[idx_q];
    sum_d  = sum_q + {2'b00, v};
    best_d = best_q;
    mask_d = mask_q;
    tie_d  = tie_q;
    if (v > best_q) begin
      best_d = v;
      mask_d = 4'b0001 << idx_q;
      tie_d  = 1'b0;
    end else if ((v == best_q) && (v != '0)) begin
      mask_d = mask_q | (4'b0001 << idx_q);
      tie_d  = 1'b1;
    end
  end

  // Controller: snapshot, four scan cycles, then publish and hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      best_q         <= '0;
      mask_q         <= 4'b0000;
      sum_q          <= '0;
      tie_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_q       <= 4'b0000;
      winner_count_q <= '0;
      tie_out_q      <= 1'b0;
      no_votes_q     <= 1'b0;
      total_q        <= '0;
    end else if (bus.clear) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      best_q         <= '0;
      mask_q         <= 4'b0000;
      sum_q          <= '0;
      tie_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_q       <= 4'b0000;
      winner_count_q <= '0;
      tie_out_q      <= 1'b0;
      no_votes_q     <= 1'b0;
      total_q        <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.close_poll) begin
            snap_q[0] <= bus.count_a;
            snap_q[1] <= bus.count_b;
            snap_q[2] <= bus.count_c;
            snap_q[3] <= bus.count_d;
            best_q    <= '0;
            mask_q    <= 4'b0000;
            sum_q     <= '0;
            tie_q     <= 1'b0;
            idx_q     <= 2'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          best_q <= best_d;
          mask_q <= mask_d;
          sum_q  <= sum_d;
          tie_q  <= tie_d;
          idx_q  <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q        <= DONE;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            winner_count_q <= best_d;
            total_q        <= sum_d;
            no_votes_q     <= (sum_d == '0);
            winner_q       <= (sum_d == '0) ? 4'b0000 : mask_d;
            tie_out_q      <= (sum_d == '0) ? 1'b0 : tie_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner       = winner_q;
  assign bus.winner_count = winner_count_q;
  assign bus.tie          = tie_out_q;
  assign bus.no_votes     = no_votes_q;
  assign bus.total_votes  = total_q;

endmodule

// File: tb/tb_evm_result_tally.sv
// tb/tb_evm_result_tally.sv - self-checking bench for evm_result_tally
module tb_evm_result_tally;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   last_tot;

  evm_result_tally_if #(.CNT_W(4)) bus ();

  evm_result_tally #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a, b, c, d;
    logic [3:0] w;
    logic [3:0] wc;
    logic       tie;
    logic       nv;
    logic [5:0] tot;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: leaders are all candidates equal to the maximum, if any votes were cast
  task automatic model(input logic [3:0] a, b, c, d,
                       output logic [3:0] w, output logic [3:0] wc,
                       output logic t, output logic nv, output logic [5:0] tot);
    int vals [4];
    int mx, sum, pop;
    vals = '{int'(a), int'(b), int'(c), int'(d)};
    mx = 0; sum = 0; pop = 0; w = 4'b0000;
    foreach (vals[i]) begin
      sum += vals[i];
      if (vals[i] > mx) mx = vals[i];
    end
    if (sum != 0) begin
      foreach (vals[i]) if (vals[i] == mx) begin w[i] = 1'b1; pop++; end
    end
    wc  = 4'(mx);
    t   = (pop > 1);
    nv  = (sum == 0);
    tot = 6'(sum);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_winner"}, 32'(bus.winner), 0);
    chk({tag, "_wcount"}, 32'(bus.winner_count), 0);
    chk({tag, "_tie"}, 32'(bus.tie), 0);
    chk({tag, "_novotes"}, 32'(bus.no_votes), 0);
    chk({tag, "_total"}, 32'(bus.total_votes), 0);
  endtask

  // mode 0: plain run; 1: close_poll held during scan; 2: inputs disturbed after snapshot
  task automatic run_poll(input logic [3:0] a, b, c, d, input int mode);
    bus.count_a = a; bus.count_b = b; bus.count_c = c; bus.count_d = d;
    bus.close_poll = 1'b1;
    tick();
    if (mode != 1) bus.close_poll = 1'b0;
    if (mode == 2) begin
      bus.count_b = 4'd0;
      bus.count_a = 4'($urandom_range(0, 15));
      bus.count_d = 4'($urandom_range(0, 15));
    end
    chk("busy_N", 32'(bus.busy), 1);
    chk("done_N", 32'(bus.done), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("busy_scan", 32'(bus.busy), 1);
      chk("done_scan", 32'(bus.done), 0);
      chk("hold_total", 32'(bus.total_votes), 32'(last_tot));
    end
    bus.close_poll = 1'b0;
    tick();
    chk("busy_pub", 32'(bus.busy), 0);
    chk("done_pub", 32'(bus.done), 1);
  endtask

  task automatic chk_model(input logic [3:0] a, b, c, d);
    logic [3:0] w, wc;
    logic t, nv;
    logic [5:0] tot;
    model(a, b, c, d, w, wc, t, nv, tot);
    chk("m_winner", 32'(bus.winner), 32'(w));
    chk("m_wcount", 32'(bus.winner_count), 32'(wc));
    chk("m_tie", 32'(bus.tie), 32'(t));
    chk("m_novotes", 32'(bus.no_votes), 32'(nv));
    chk("m_total", 32'(bus.total_votes), 32'(tot));
    last_tot = int'(tot);
  endtask

  initial begin
    n_pass = 0; n_total = 0; last_tot = 0;
    rst = 1'b0;
    bus.close_poll = 1'b0; bus.clear = 1'b0;
    bus.count_a = '0; bus.count_b = '0; bus.count_c = '0; bus.count_d = '0;

    vecs[0] = '{"clear_winner", 4'd3, 4'd7, 4'd2, 4'd5, 4'b0010, 4'd7, 1'b0, 1'b0, 6'd17};
    vecs[1] = '{"three_tie",    4'd6, 4'd2, 4'd6, 4'd6, 4'b1101, 4'd6, 1'b1, 1'b0, 6'd20};
    vecs[2] = '{"empty",        4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'd0, 1'b0, 1'b1, 6'd0};
    vecs[3] = '{"saturated",    4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 4'd15, 1'b1, 1'b0, 6'd60};
    vecs[4] = '{"lone_c",       4'd0, 4'd0, 4'd9, 4'd0, 4'b0100, 4'd9, 1'b0, 1'b0, 6'd9};
    vecs[5] = '{"tie_ab",       4'd4, 4'd4, 4'd0, 4'd0, 4'b0011, 4'd4, 1'b1, 1'b0, 6'd8};

    tick(); tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_poll(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 0);
      chk({vecs[i].name, "_winner"}, 32'(bus.winner), 32'(vecs[i].w));
      chk({vecs[i].name, "_wcount"}, 32'(bus.winner_count), 32'(vecs[i].wc));
      chk({vecs[i].name, "_tie"}, 32'(bus.tie), 32'(vecs[i].tie));
      chk({vecs[i].name, "_novotes"}, 32'(bus.no_votes), 32'(vecs[i].nv));
      chk({vecs[i].name, "_total"}, 32'(bus.total_votes), 32'(vecs[i].tot));
      last_tot = int'(vecs[i].tot);
      tick(); tick();
      chk({vecs[i].name, "_done_held"}, 32'(bus.done), 1);
    end

    // close_poll repeated while scanning is ignored
    run_poll(4'd3, 4'd7, 4'd2, 4'd5, 1);
    chk_model(4'd3, 4'd7, 4'd2, 4'd5);

    // inputs changed after the snapshot edge do not affect the run
    run_poll(4'd15, 4'd15, 4'd15, 4'd15, 2);
    chk_model(4'd15, 4'd15, 4'd15, 4'd15);

    // clear two edges into a scan aborts without publishing
    bus.count_a = 4'd1; bus.count_b = 4'd8; bus.count_c = 4'd8; bus.count_d = 4'd2;
    bus.close_poll = 1'b1;
    tick();
    bus.close_poll = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk_zero("clr_scan");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clr_scan_nodone", 32'(bus.done), 0);
      chk("clr_scan_nobusy", 32'(bus.busy), 0);
    end
    last_tot = 0;

    // clear beats close_poll in DONE
    run_poll(4'd1, 4'd2, 4'd3, 4'd4, 0);
    chk_model(4'd1, 4'd2, 4'd3, 4'd4);
    bus.clear = 1'b1; bus.close_poll = 1'b1;
    tick();
    bus.clear = 1'b0; bus.close_poll = 1'b0;
    chk_zero("clr_close");
    for (int k = 0; k < 5; k++) tick();
    chk("clr_close_idle_busy", 32'(bus.busy), 0);
    chk("clr_close_idle_done", 32'(bus.done), 0);
    last_tot = 0;

    // randomized polls against the reference
    for (int r = 0; r < 30; r++) begin
      logic [3:0] ra, rb, rc, rd;
      if ($urandom_range(0, 1) == 1) begin
        ra = 4'($urandom_range(0, 3)); rb = 4'($urandom_range(0, 3));
        rc = 4'($urandom_range(0, 3)); rd = 4'($urandom_range(0, 3));
      end else begin
        ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
        rc = 4'($urandom_range(0, 15)); rd = 4'($urandom_range(0, 15));
      end
      run_poll(ra, rb, rc, rd, 0);
      chk_model(ra, rb, rc, rd);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // asynchronous reset in mid-scan, no clock edge while asserted
    bus.count_a = 4'd5; bus.count_b = 4'd5; bus.count_c = 4'd1; bus.count_d = 4'd0;
    bus.close_poll = 1'b1;
    tick();
    bus.close_poll = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    #1;
    rst = 1'b1;
    tick(); tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    chk("post_rst_total", 32'(bus.total_votes), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/evm_result_tally.md
# evm_result_tally

Downstream result stage for the EVM voting FSM. When polling closes, it snapshots the four per-candidate vote counters and scans them sequentially, one candidate per cycle. It then publishes a registered result: one-hot winner mask, winning count, tie flag, no-vote flag and total votes cast. The result drives the display/announcement logic and holds stable until cleared or re-run.

## Interface
- CNT_W, 4, width of each candidate count; must match the counter width of the voting FSM.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- close_poll  input  1  single-cycle request to compute results; sampled only in IDLE or DONE.
- clear  input  1  synchronous clear; returns to IDLE and zeroes all outputs; has priority over close_poll.
- count_a, count_b, count_c, count_d  input  CNT_W each  per-candidate totals from the voting FSM.
- busy  output  1  high while the scan is in progress.
- done  output  1  high while a published result is held.
- winner  output  4  one-hot/multi-hot mask; bit0=A, bit1=B, bit2=C, bit3=D; all tied leaders are set.
- winner_count  output  CNT_W  vote count of the leader(s).
- tie  output  1  two or more candidates share a nonzero maximum.
- no_votes  output  1  all four counts were zero.
- total_votes  output  CNT_W+2  sum of the four snapshot counts (max 4*(2^CNT_W-1), no overflow).

## Operation
- States:
  - IDLE: waits for close_poll.
  - SCAN: 2-bit index idx runs 0..3.
  - DONE: holds the published result.
- IDLE + close_poll:
  - Snapshot all four counts into internal registers.
  - Clear working regs: best=0, mask=0, sum=0, tie_w=0.
  - Set idx=0 and go to SCAN.
- SCAN, one candidate per cycle, using v = snap[idx]:
  - sum += v.
  - If v > best: best=v, mask=onehot(idx), tie_w=0.
  - Else if v == best and v != 0: mask |= onehot(idx), tie_w=1.
  - Else: no change.
  - When idx==3, go to DONE and load the outputs from the final working values.
- Publishing:
  - winner=mask, winner_count=best, tie=tie_w, total_votes=sum.
  - no_votes=(sum==0).
  - If sum==0, winner=0000 and tie=0.
- Outputs change only at the publish edge. Working registers are internal, so no partial results are ever visible.
- DONE + close_poll: starts a new run exactly as from IDLE. done drops and busy rises on that edge; the old outputs hold until the new publish.
- Input changes after the snapshot edge have no effect on the current run.
- close_poll while in SCAN is ignored.
- clear in any state:
  - Next state is IDLE.
  - All outputs and working registers go to 0.
  - An in-progress scan is aborted without publishing.
  - clear and close_poll on the same edge: clear wins.
- rst low: immediately forces IDLE and zeroes all registers, regardless of clk.

## Timing
- Reset values: busy=0, done=0, winner=0000, winner_count=0, tie=0, no_votes=0, total_votes=0.
- close_poll high at edge N (IDLE or DONE):
  - Snapshot taken at N; busy=1 from N.
  - Scan of idx 0,1,2,3 occurs at edges N+1..N+4.
  - At edge N+4: outputs published, busy=0, done=1.
- Latency: 4 cycles from the close_poll sample edge to done.
- done stays high indefinitely until clear, rst, or a new close_poll.
- busy and done are never high together.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: assert rst low mid-SCAN, with no clock edge during assertion → all outputs 0 immediately, busy=0; release rst → stays in IDLE.
- Clear winner: A=3, B=7, C=2, D=5, pulse close_poll → done at N+4 with winner=0010, winner_count=7, tie=0, no_votes=0, total_votes=17; busy high for exactly edges N..N+3.
- Three-way tie: A=6, B=2, C=6, D=6 → winner=1101, winner_count=6, tie=1, total_votes=20.
- Empty poll: all counts 0 → winner=0000, winner_count=0, tie=0, no_votes=1, total_votes=0.
- Saturated, with input change: all counts 15 → winner=1111, tie=1, total_votes=60. Change count_b to 0 at N+1 → result unchanged.
- Control hazards:
  - close_poll repeated during SCAN → ignored; done still at N+4.
  - clear at N+2 → IDLE, outputs 0, done never asserts.
  - clear together with close_poll in DONE → IDLE, outputs zeroed.
